// File: rtl/cpu6_insn_encoder.sv
// cpu6_insn_encoder
// Packs RV32I instruction fields into 32-bit instruction words for the boot/test
// loader and hands them to instruction memory at sequential byte addresses.
// Two-stage pipeline: S1 holds the accepted request, and S2 holds the encoded word.
// Fields are validated on the way out of S1. A rejected request raises a
// one-cycle err_valid pulse, writes nothing, and leaves the address pointer as is.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   restart            synchronous flush of both stages, address pointer and word counter
//   req_valid/ready    request handshake
//   req_op..req_imm    opcode, funct3, funct7, rd, rs1, rs2, signed immediate
//   wr_valid/ready     encoded-word handshake towards imem
//   wr_addr, wr_data   byte address and encoded word
//   err_valid/code     rejection pulse and reason (code held between pulses)
//   word_count         accepted words, saturating

module cpu6_insn_encoder #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH_WORDS - 1));

    logic              s1_valid;
    logic [6:0]        s1_op;
    logic [2:0]        s1_f3;
    logic [6:0]        s1_f7;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [31:0]       s1_imm;
    logic [ADDR_W-1:0] addr_ptr;

    logic [31:0] enc;
    logic [2:0]  code;
    logic        s1_err;
    logic        s2_free;
    logic        s1_adv;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;
    logic        is_shift;

    // Range checks work as sign-extension tests. For B and J, the largest odd
    // value passes the sign-extension test but is still outside the legal range.
    assign imm_i_ok = (s1_imm[31:11] == {21{s1_imm[11]}});
    assign imm_b_ok = (s1_imm[31:12] == {20{s1_imm[12]}}) && (s1_imm != 32'h0000_0FFF);
    assign imm_j_ok = (s1_imm[31:20] == {12{s1_imm[20]}}) && (s1_imm != 32'h000F_FFFF);
    assign is_shift = (s1_f3 == 3'd1) || (s1_f3 == 3'd5);

    always_comb begin
        enc  = '0;
        code = 3'd0;
        case (s1_op)
            7'h33: begin
                enc = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
                if ((s1_f7 != 7'h00 && s1_f7 != 7'h20) ||
                    (s1_f7 == 7'h20 && s1_f3 != 3'd0 && s1_f3 != 3'd5))
                    code = 3'd5;
            end
            7'h03, 7'h67, 7'h0F: begin
                enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                if (!imm_i_ok)
                    code = 3'd2;
                else if (s1_op == 7'h03 && (s1_f3 == 3'd3 || s1_f3 == 3'd6 || s1_f3 == 3'd7))
                    code = 3'd5;
                else if (s1_op == 7'h67 && s1_f3 != 3'd0)
                    code = 3'd5;
            end
            7'h13: begin
                if (is_shift)
                    enc = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
                else
                    enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                // A shift amount is unsigned, so a negative imm is also out of range.
                if (!imm_i_ok)
                    code = 3'd2;
                else if (is_shift && ((s1_imm[31:5] != 27'd0) ||
                         (s1_f3 == 3'd1 && s1_f7 != 7'h00) ||
                         (s1_f3 == 3'd5 && s1_f7 != 7'h00 && s1_f7 != 7'h20)))
                    code = 3'd4;
            end
            7'h23: begin
                enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
                if (!imm_i_ok)
                    code = 3'd2;
                else if (s1_f3 > 3'd2)
                    code = 3'd5;
            end
            7'h63: begin
                enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                       s1_imm[4:1], s1_imm[11], s1_op};
                if (!imm_b_ok)
                    code = 3'd2;
                else if (s1_imm[0])
                    code = 3'd3;
                else if (s1_f3 == 3'd2 || s1_f3 == 3'd3)
                    code = 3'd5;
            end
            7'h37, 7'h17: begin
                enc = {s1_imm[31:12], s1_rd, s1_op};
                if (s1_imm[11:0] != 12'd0)
                    code = 3'd2;
            end
            7'h6F: begin
                enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
                if (!imm_j_ok)
                    code = 3'd2;
                else if (s1_imm[0])
                    code = 3'd3;
            end
            default: code = 3'd1;
        endcase
    end

    assign s1_err    = (code != 3'd0);
    assign s2_free   = !wr_valid || wr_ready;
    // Rejected requests leave S1 without waiting for room in S2.
    assign s1_adv    = s1_valid && (s1_err || s2_free);
    assign req_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk) begin
        if (!resetn || restart) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_f3      <= '0;
            s1_f7      <= '0;
            s1_rd      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_imm     <= '0;
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= BASE_ADDR;
            addr_ptr   <= BASE_ADDR;
            err_valid  <= 1'b0;
            err_code   <= 3'd0;
            word_count <= 16'd0;
        end else begin
            if (req_valid && req_ready) begin
                s1_valid <= 1'b1;
                s1_op    <= req_op;
                s1_f3    <= req_funct3;
                s1_f7    <= req_funct7;
                s1_rd    <= req_rd;
                s1_rs1   <= req_rs1;
                s1_rs2   <= req_rs2;
                s1_imm   <= req_imm;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv && !s1_err) begin
                wr_valid <= 1'b1;
                wr_data  <= enc;
                wr_addr  <= addr_ptr;
                addr_ptr <= (addr_ptr == LAST_ADDR) ? BASE_ADDR : addr_ptr + ADDR_W'(4);
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end

            err_valid <= s1_adv && s1_err;
            if (s1_adv && s1_err)
                err_code <= code;

            if (wr_valid && wr_ready && word_count != 16'hFFFF)
                word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cpu6_insn_encoder.sv
// Directed bench for cpu6_insn_encoder, instantiated with a four-word address window.

module tb_cpu6_insn_encoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        restart;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_op;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    logic saw_stall;
    logic [31:0] exp_ptr;

    logic [31:0] wq_data[$];
    logic [31:0] wq_addr[$];
    logic [2:0]  eq[$];

    cpu6_insn_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(4)) dut (
        .clk(clk), .resetn(resetn), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_valid(err_valid), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && !restart) begin
            if (wr_valid && wr_ready) begin
                wq_data.push_back(wr_data);
                wq_addr.push_back(wr_addr);
                n_hs++;
            end
            if (err_valid)
                eq.push_back(err_code);
        end
    end

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == 32'hC) ? 32'h0 : a + 32'd4;
    endfunction

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        logic accepted;
        accepted   = 1'b0;
        req_op     = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (!req_ready) saw_stall = 1'b1;
            accepted = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL send_accept: op=%h not accepted within 40 cycles", op);
        end
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 50 && wq_data.size() < n; i++) @(posedge clk);
        #1;
        n_checks++;
        if (wq_data.size() != n) begin
            n_fail++;
            $display("FAIL word_total: got %0d words, required %0d", wq_data.size(), n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; restart = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
        req_op = '0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b required 0", wr_valid); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid: got %b required 0", err_valid); end
        n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d required 0", err_code); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
        n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
        resetn = 1'b1;
        exp_ptr = 32'h0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_latency();
        wq_data.delete(); wq_addr.delete();
        wr_ready = 1'b1;
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1: wr_valid got %b required 0", wr_valid); end
        @(posedge clk); #1;
        n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL latency_n2: wr_valid got %b required 1", wr_valid); end
        n_checks++; if (wr_data !== 32'hFFF10093) begin n_fail++; $display("FAIL addi_data: got %h required FFF10093", wr_data); end
        n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL addi_addr: got %h required 0", wr_addr); end
        exp_ptr = next_addr(exp_ptr);
        wait_words(1);
    endtask

    task automatic test_formats();
        logic [31:0] exp_d [7];
        logic [31:0] a;
        exp_d = '{32'h00512423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7,
                  32'h402081B3, 32'h40335293, 32'hFF812083};
        wq_data.delete(); wq_addr.delete();
        send(7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'd8);
        send(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        send(7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3);
        send(7'h03, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8);
        wait_words(7);
        a = exp_ptr;
        for (int i = 0; i < 7 && i < wq_data.size(); i++) begin
            n_checks++;
            if (wq_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL fmt_data[%0d]: got %h required %h", i, wq_data[i], exp_d[i]); end
            n_checks++;
            if (wq_addr[i] !== a) begin n_fail++; $display("FAIL fmt_addr[%0d]: got %h required %h", i, wq_addr[i], a); end
            a = next_addr(a);
        end
        exp_ptr = a;
        @(negedge clk);
        n_checks++; if (word_count !== 16'(n_hs)) begin n_fail++; $display("FAIL fmt_word_count: got %0d required %0d", word_count, n_hs); end
    endtask

    task automatic test_errors();
        logic [2:0] exp_c [15];
        exp_c = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd2, 3'd4, 3'd4, 3'd5,
                  3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd2, 3'd3};
        @(posedge clk); #1;
        wq_data.delete(); wq_addr.delete(); eq.delete();
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd2048);
        send(7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0);
        send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
        send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096);
        send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4095);
        send(7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd32);
        send(7'h13, 3'd5, 7'h10, 5'd1, 5'd2, 5'd0, 32'd1);
        send(7'h03, 3'd3, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0);
        send(7'h23, 3'd3, 7'h00, 5'd0, 5'd2, 5'd1, 32'd0);
        send(7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
        send(7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd3, 32'd0);
        send(7'h67, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0);
        send(7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h1234_5001);
        send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (eq.size() != 15) begin n_fail++; $display("FAIL err_pulses: got %0d required 15", eq.size()); end
        for (int i = 0; i < 15 && i < eq.size(); i++) begin
            n_checks++;
            if (eq[i] !== exp_c[i]) begin n_fail++; $display("FAIL err_code[%0d]: got %0d required %0d", i, eq[i], exp_c[i]); end
        end
        n_checks++; if (wq_data.size() != 0) begin n_fail++; $display("FAIL err_no_write: got %0d words required 0", wq_data.size()); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end: got %b required 0", err_valid); end
        n_checks++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL err_code_hold: got %0d required 3", err_code); end
        send(7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        wait_words(1);
        if (wq_data.size() > 0) begin
            n_checks++;
            if (wq_addr[0] !== exp_ptr) begin n_fail++; $display("FAIL err_next_addr: got %h required %h", wq_addr[0], exp_ptr); end
            n_checks++;
            if (wq_data[0] !== 32'hFFF10093) begin n_fail++; $display("FAIL err_next_data: got %h required FFF10093", wq_data[0]); end
        end
        exp_ptr = next_addr(exp_ptr);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        logic [31:0] a;
        exp_d = '{32'h00100093, 32'h00200113, 32'h00300193};
        @(posedge clk); #1;
        wq_data.delete(); wq_addr.delete();
        wr_ready  = 1'b0;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (wr_valid) begin
                        n_checks++;
                        if (wr_data !== exp_d[0]) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h required %h", i, wr_data, exp_d[0]); end
                    end
                end
                @(posedge clk); #1;
                wr_ready = 1'b1;
            end
            begin
                send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
                send(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2);
                send(7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3);
            end
        join
        wait_words(3);
        n_checks++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready_low: got %b required 1", saw_stall); end
        a = exp_ptr;
        for (int i = 0; i < 3 && i < wq_data.size(); i++) begin
            n_checks++;
            if (wq_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wq_data[i], exp_d[i]); end
            n_checks++;
            if (wq_addr[i] !== a) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h required %h", i, wq_addr[i], a); end
            a = next_addr(a);
        end
        exp_ptr = a;
        @(negedge clk);
        n_checks++; if (word_count !== 16'(n_hs)) begin n_fail++; $display("FAIL b2b_word_count: got %0d required %0d", word_count, n_hs); end
    endtask

    task automatic test_restart();
        @(posedge clk); #1;
        wr_ready = 1'b0;
        send(7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4);
        send(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd5);
        n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_full: wr_valid got %b required 1", wr_valid); end
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        n_hs = 0; exp_ptr = 32'h0;
        wq_data.delete(); wq_addr.delete(); eq.delete();
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b required 0", wr_valid); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL rst_word_count: got %0d required 0", word_count); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rst_err_valid: got %b required 0", err_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
        wr_ready = 1'b1;
        send(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        repeat (4) @(posedge clk);
        wait_words(1);
        if (wq_data.size() > 0) begin
            n_checks++;
            if (wq_addr[0] !== 32'h0) begin n_fail++; $display("FAIL rst_next_addr: got %h required 0", wq_addr[0]); end
            n_checks++;
            if (wq_data[0] !== 32'h123452B7) begin n_fail++; $display("FAIL rst_next_data: got %h required 123452B7", wq_data[0]); end
        end
        n_checks++; if (eq.size() != 0) begin n_fail++; $display("FAIL rst_no_err: got %0d pulses required 0", eq.size()); end
        @(negedge clk);
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL rst_word_count_after: got %0d required 1", word_count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_formats();
        test_errors();
        test_back_to_back();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
